// File: rtl/mss_pkg.sv
// Shared types and constants for the MSS stream reader slice.
// Optional build macro: MSS_RD_PARITY_EN adds a per-word even-parity bit to the stream.
package mss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int RD_BUF_DEPTH = 2;
  localparam int RD_PTR_W     = $clog2(RD_BUF_DEPTH);
  localparam int RD_CNT_W     = $clog2(RD_BUF_DEPTH + 1);

  localparam int MSS_ADDR_W = 8;
  localparam int MSS_DATA_W = 16;

endpackage

// File: rtl/mss_stream_reader_if.sv
// RAM read port and output stream of the MSS stream reader.
// Optional build macro: MSS_RD_PARITY_EN adds out_parity to the stream.
interface mss_stream_reader_if
  import mss_pkg::*;
#(
  parameter int ADDR_W = MSS_ADDR_W,
  parameter int DATA_W = MSS_DATA_W
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef MSS_RD_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    output out_data,
    output out_last,
`ifdef MSS_RD_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    input  out_data,
    input  out_last,
`ifdef MSS_RD_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );

endinterface

// File: rtl/mss_rd_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency and stream backpressure.
// Simultaneous push and pop are both performed; storage is not reset.
module mss_rd_skid_fifo
  import mss_pkg::*;
#(
  parameter int WIDTH = MSS_DATA_W + 1
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [WIDTH-1:0]    i_din,
  output logic [WIDTH-1:0]    o_dout,
  output logic                o_full,
  output logic                o_empty,
  output logic [RD_CNT_W-1:0] o_count
);

  logic [WIDTH-1:0]    r_mem [RD_BUF_DEPTH];
  logic [RD_PTR_W-1:0] r_wr_ptr;
  logic [RD_PTR_W-1:0] r_rd_ptr;
  logic [RD_CNT_W-1:0] r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == RD_CNT_W'(RD_BUF_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + RD_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + RD_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + RD_CNT_W'(1);
        2'b01:   r_count <= r_count - RD_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mss_stream_reader.sv
// Reads one frame from a sync-read RAM at the MSS counter address and streams it out.
// Optional build macro: MSS_RD_PARITY_EN stores and presents an even-parity bit per word.
module mss_stream_reader
  import mss_pkg::*;
#(
  parameter int ADDR_W = MSS_ADDR_W,
  parameter int DATA_W = MSS_DATA_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              advance,
  output logic              busy,
  output logic              frame_done,
  mss_stream_reader_if.master bus
);

`ifdef MSS_RD_PARITY_EN
  localparam int ENT_W = DATA_W + 2;
`else
  localparam int ENT_W = DATA_W + 1;
`endif

  rd_state_e           r_state;
  rd_state_e           w_state_nxt;
  logic                r_inflight;
  logic                r_inflight_last;
  logic                w_issue;
  logic                w_credit;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [RD_CNT_W-1:0] w_count;
  logic [RD_CNT_W:0]   w_occ;
  logic [ENT_W-1:0]    w_push_ent;
  logic [ENT_W-1:0]    w_head;

  // A word leaving the buffer this cycle frees its slot for a new read, which keeps 1 word/cycle.
  assign w_pop    = !w_empty && bus.out_ready;
  assign w_occ    = {1'b0, w_count} + (RD_CNT_W+1)'(r_inflight) - (RD_CNT_W+1)'(w_pop);
  assign w_credit = !(w_full && !w_pop) && (w_occ < (RD_CNT_W+1)'(RD_BUF_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = RUN;
      RUN: begin
        if (stop) begin
          w_state_nxt = DRAIN;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (addr_in == '1) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty && !r_inflight) begin
          w_state_nxt = IDLE;
          frame_done  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state         <= IDLE;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (addr_in == '1);
    end
  end

`ifdef MSS_RD_PARITY_EN
  assign w_push_ent     = {^bus.mem_rd_data, r_inflight_last, bus.mem_rd_data};
  assign bus.out_parity = !w_empty && w_head[DATA_W+1];
`else
  assign w_push_ent     = {r_inflight_last, bus.mem_rd_data};
`endif

  mss_rd_skid_fifo #(.WIDTH(ENT_W)) u_fifo (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (w_push_ent),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Stream outputs are forced to zero while the buffer is empty.
  assign advance         = w_issue;
  assign busy            = (r_state != IDLE);
  assign bus.mem_rd_en   = w_issue;
  assign bus.mem_rd_addr = addr_in;
  assign bus.out_valid   = !w_empty;
  assign bus.out_data    = w_empty ? '0 : w_head[DATA_W-1:0];
  assign bus.out_last    = !w_empty && w_head[DATA_W];

endmodule

// File: tb/tb_mss_stream_reader.sv
// Scoreboard bench for mss_stream_reader with a behavioural counter and sync-read RAM.
// Build with MSS_RD_PARITY_EN defined to also check out_parity.
module tb_mss_stream_reader;
  import mss_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic          par;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] cnt;
  logic          cnt_load = 1'b1;
  logic [AW-1:0] cnt_val = '0;
  logic          advance;
  logic          busy;
  logic          frame_done;

  mss_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mss_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .start      (start),
    .stop       (stop),
    .addr_in    (cnt),
    .advance    (advance),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] ram [256];
  int unsigned   adv_total = 0;
  int unsigned   n_xfer = 0;
  int unsigned   fd_total = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            rmode = 3;
  exp_t          expq[$];

  // Address counter and RAM models
  always @(posedge CLK) begin
    if (cnt_load)     cnt <= cnt_val;
    else if (advance) cnt <= cnt + 8'd1;
    if (RESETn && advance) adv_total <= adv_total + 1;
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer ready pattern
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer
  initial begin
    exp_t          e;
    logic          prev_stall;
    logic [DW:0]   prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        prev_stall = 1'b0;
      end else begin
        chk("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(cnt));
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_word", 32'({bus.out_last, bus.out_data}), 32'(prev_word));
        end
        if (!bus.out_valid) begin
          chk("idle_word", 32'({bus.out_last, bus.out_data}), 32'd0);
`ifdef MSS_RD_PARITY_EN
          chk("idle_parity", 32'(bus.out_parity), 32'd0);
`endif
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
          end else begin
            e = expq.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e.data));
            chk("out_last", 32'(bus.out_last), 32'(e.last));
`ifdef MSS_RD_PARITY_EN
            chk("out_parity", 32'(bus.out_parity), 32'(e.par));
`endif
          end
          n_xfer++;
        end
        if (frame_done) fd_total++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_word  = {bus.out_last, bus.out_data};
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic load_cnt(input logic [AW-1:0] v);
    step(); cnt_load = 1'b1; cnt_val = v;
    step(); cnt_load = 1'b0;
  endtask

  task automatic pulse_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  // Reference: a frame is every address from the start address up to all-ones
  task automatic expect_frame(input int a);
    for (int x = a; x < 256; x++)
      expq.push_back('{par: ^ram[x], last: (x == 255), data: ram[x]});
  endtask

  task automatic wait_done(input int bound, input string name);
    bit got = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge CLK);
      if (frame_done) begin got = 1; break; end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  initial begin
    int unsigned a0, x0, a_stop, nd, fd0;
    int          sa;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_advance", 32'(advance), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_word", 32'({bus.out_last, bus.out_data}), 32'd0);
    chk("rst_rd_addr", 32'(bus.mem_rd_addr), 32'(cnt));
    step(); RESETn = 1'b1; cnt_load = 1'b0;

    // Full-rate frame from 0xFC with RAM[a]=a
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    rmode = 0;
    load_cnt(8'hFC);
    expect_frame(8'hFC);
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k <= 4) chk("t1_advance_on", 32'(advance), 32'd1);
      else        chk("t1_advance_off", 32'(advance), 32'd0);
      if (k <= 2)      chk("t1_valid_lat", 32'(bus.out_valid), 32'd0);
      else if (k <= 6) chk("t1_valid_run", 32'(bus.out_valid), 32'd1);
      chk("t1_frame_done", 32'(frame_done), 32'(k == 7));
    end
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_cnt", 32'(cnt), 32'h00);
    chk("t1_queue", 32'(expq.size()), 32'd0);

    // Full frame with toggling ready and random data
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    rmode = 1;
    load_cnt(8'h00);
    expect_frame(0);
    a0 = adv_total; x0 = n_xfer;
    pulse_start();
    wait_done(1500, "t2_done");
    @(negedge CLK);
    chk("t2_advances", adv_total - a0, 32'd256);
    chk("t2_words", n_xfer - x0, 32'd256);
    chk("t2_queue", 32'(expq.size()), 32'd0);

    // Backpressure: only two reads outstanding
    rmode = 3;
    load_cnt(8'h00);
    expect_frame(0);
    a0 = adv_total; x0 = n_xfer;
    pulse_start();
    repeat (10) @(negedge CLK);
    chk("t3_advances_held", adv_total - a0, 32'd2);
    chk("t3_valid_held", 32'(bus.out_valid), 32'd1);
    chk("t3_data_held", 32'(bus.out_data), 32'(ram[0]));
    rmode = 0;
    wait_done(600, "t3_done");
    @(negedge CLK);
    chk("t3_advances", adv_total - a0, 32'd256);
    chk("t3_words", n_xfer - x0, 32'd256);

    // Stop mid-frame, then resume from the counter
    rmode = 2;
    load_cnt(8'h10);
    expect_frame(8'h10);
    a0 = adv_total; x0 = n_xfer;
    pulse_start();
    repeat (4) step();
    stop = 1'b1;
    @(negedge CLK);
    chk("t4_stop_adv", 32'(advance), 32'd0);
    a_stop = adv_total;
    step(); stop = 1'b0;
    wait_done(200, "t4_done");
    @(negedge CLK);
    nd = n_xfer - x0;
    chk("t4_no_adv_after_stop", adv_total, a_stop);
    chk("t4_words_eq_reads", nd, adv_total - a0);
    chk("t4_cnt", 32'(cnt), 32'((16 + nd) & 255));
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_remaining", 32'(expq.size()), 32'(240 - nd));
    expq.delete();
    rmode = 0;
    sa = int'(cnt);
    expect_frame(sa);
    pulse_start();
    wait_done(400, "t4_resume_done");
    @(negedge CLK);
    chk("t4_resume_queue", 32'(expq.size()), 32'd0);

    // Random short frames near the top of the address space
    for (int r = 0; r < 4; r++) begin
      for (int i = 192; i < 256; i++) ram[i] = 16'($urandom);
      sa = (r == 0) ? 255 : int'($urandom_range(192, 254));
      rmode = 2;
      load_cnt(8'(sa));
      expect_frame(sa);
      pulse_start();
      wait_done(600, "rnd_done");
      @(negedge CLK);
      chk("rnd_queue", 32'(expq.size()), 32'd0);
    end

    // Reset with the buffer full
    rmode = 3;
    load_cnt(8'h40);
    expect_frame(8'h40);
    fd0 = fd_total; a0 = adv_total;
    pulse_start();
    repeat (6) @(negedge CLK);
    chk("t5_full_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_full_reads", adv_total - a0, 32'd2);
    step(); RESETn = 1'b0;
    @(negedge CLK);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_advance", 32'(advance), 32'd0);
    chk("t5_frame_done", 32'(frame_done), 32'd0);
    repeat (2) step();
    expq.delete();
    RESETn = 1'b1;
    rmode = 0;
    repeat (3) @(negedge CLK);
    chk("t5_no_frame_done", fd_total, fd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // Two-word frame with odd/even parity data
    ram[254] = 16'h0001;
    ram[255] = 16'h0003;
    load_cnt(8'hFE);
    expect_frame(254);
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (k == 3) begin
        chk("t6_word0", 32'(bus.out_data), 32'h0001);
`ifdef MSS_RD_PARITY_EN
        chk("t6_parity0", 32'(bus.out_parity), 32'd1);
`endif
      end
      if (k == 4) begin
        chk("t6_word1", 32'(bus.out_data), 32'h0003);
`ifdef MSS_RD_PARITY_EN
        chk("t6_parity1", 32'(bus.out_parity), 32'd0);
`endif
      end
    end
    wait_done(20, "t6_done");
    @(negedge CLK);
    chk("t6_queue", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
